// File: rtl/alu_pipeline_regs.sv
// Pipelined add/sub unit: one ALU_WIDTH chunk per stage, carries registered between
// stages, upper operand chunks skewed forward and lower sum chunks carried along.
module alu_pipeline_regs_chunk #(
    parameter int W    = 4,
    parameter int TYPE = 0
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_add_nsub,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);
    logic [W-1:0] w_b;

    always_comb begin
        if (TYPE == 0 || (TYPE == 2 && i_add_nsub)) w_b = i_b;
        else                                          w_b = ~i_b;
    end

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, w_b} + {{W{1'b0}}, i_cin};
endmodule

module alu_pipeline_regs #(
    parameter int WIDTH     = 15,
    parameter int ALU_WIDTH = 4,
    parameter int TYPE      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             add_nsub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int C = (WIDTH + ALU_WIDTH - 1) / ALU_WIDTH;
    localparam int P = (C > 1) ? C - 1 : 1;

    if (TYPE < 0 || TYPE > 2) begin : g_bad_type
        $error("alu_pipeline_regs: TYPE must be 0 (ADD), 1 (SUB) or 2 (ADDSUB)");
    end
    if (WIDTH < 1 || ALU_WIDTH < 1) begin : g_bad_width
        $error("alu_pipeline_regs: WIDTH and ALU_WIDTH must be >= 1");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_a    [C];
    logic [WIDTH-1:0] w_b    [C];
    logic [WIDTH-1:0] w_sin  [C];
    logic [WIDTH-1:0] w_sout [C];
    logic [C-1:0]     w_mode, w_cin, w_vin, w_co;

    logic [C-1:0]     r_vld, r_carry;
    logic [WIDTH-1:0] r_sum [C];
    // Pass-through operands are stored pre-shifted so chunk k+1 always sits at bit 0.
    logic [WIDTH-1:0] r_pa  [P];
    logic [WIDTH-1:0] r_pb  [P];
    logic [P-1:0]     r_mode;

    assign w_adv     = !r_vld[C-1] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_vld[C-1];
    assign sum       = r_sum[C-1];
    assign cout      = r_carry[C-1];

    for (genvar k = 0; k < C; k++) begin : g_stg
        localparam int LO = k * ALU_WIDTH;
        localparam int CW = (k == C - 1) ? WIDTH - LO : ALU_WIDTH;
        logic [CW-1:0] w_chunk;

        if (k == 0) begin : g_first
            assign w_a[k]    = a;
            assign w_b[k]    = b;
            assign w_mode[k] = add_nsub;
            assign w_cin[k]  = cin;
            assign w_vin[k]  = in_valid;
            assign w_sin[k]  = '0;
        end else begin : g_next
            assign w_a[k]    = r_pa[k-1];
            assign w_b[k]    = r_pb[k-1];
            assign w_mode[k] = r_mode[k-1];
            assign w_cin[k]  = r_carry[k-1];
            assign w_vin[k]  = r_vld[k-1];
            assign w_sin[k]  = r_sum[k-1];
        end

        alu_pipeline_regs_chunk #(.W(CW), .TYPE(TYPE)) u_alu (
            .i_a        (w_a[k][CW-1:0]),
            .i_b        (w_b[k][CW-1:0]),
            .i_add_nsub (w_mode[k]),
            .i_cin      (w_cin[k]),
            .o_sum      (w_chunk),
            .o_cout     (w_co[k])
        );

        assign w_sout[k] = w_sin[k] | (WIDTH'(w_chunk) << LO);
    end

    // Data registers load only with a valid transaction, so the output holds its last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld   <= '0;
            r_carry <= '0;
            r_mode  <= '0;
            for (int k = 0; k < C; k++) r_sum[k] <= '0;
            for (int k = 0; k < P; k++) begin
                r_pa[k] <= '0;
                r_pb[k] <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < C; k++) begin
                r_vld[k] <= w_vin[k];
                if (w_vin[k]) begin
                    r_carry[k] <= w_co[k];
                    r_sum[k]   <= w_sout[k];
                end
            end
            for (int k = 0; k < C - 1; k++) begin
                if (w_vin[k]) begin
                    r_pa[k]   <= w_a[k] >> ALU_WIDTH;
                    r_pb[k]   <= w_b[k] >> ALU_WIDTH;
                    r_mode[k] <= w_mode[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_pipeline_regs.sv
// Scoreboard bench: four geometries/modes share one stimulus stream; a negedge monitor
// checks results, ordering, latency, stall stability, in_ready and reset state.
module tb_alu_pipeline_regs;
    localparam int ND = 4;

    function automatic int wof(input int i);
        case (i)
            0, 1:    return 15;
            2:       return 8;
            default: return 3;
        endcase
    endfunction
    function automatic int tof(input int i);
        return (i == 1) ? 2 : 0;
    endfunction
    function automatic int cof(input int i);
        return (wof(i) + 3) / 4;
    endfunction

    typedef struct {
        logic [14:0] s;
        logic        c;
        int          acc;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic add_nsub = 1'b0, cin = 1'b0;
    logic [14:0] a = '0, b = '0;
    logic [ND-1:0] v_in_ready, v_out_valid, v_cout;
    logic [14:0] v_sum [ND];

    logic        hv = 1'b0, hc0 = 1'b0, hc1 = 1'b0;
    logic [14:0] hs0 = '0, hs1 = '0;
    logic        fin_req = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int W = wof(g);
        logic [W-1:0] s;
        alu_pipeline_regs #(.WIDTH(W), .ALU_WIDTH(4), .TYPE(tof(g))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (v_in_ready[g]),
            .a         (a[W-1:0]),
            .b         (b[W-1:0]),
            .add_nsub  (add_nsub),
            .cin       (cin),
            .out_valid (v_out_valid[g]),
            .out_ready (out_ready),
            .sum       (s),
            .cout      (v_cout[g])
        );
        assign v_sum[g] = 15'(s);
    end

    function automatic exp_t model(input int i, input logic [14:0] ai, input logic [14:0] bi,
                                   input logic ci, input logic an);
        logic [15:0] m, bb, full;
        exp_t e;
        m    = (16'd1 << wof(i)) - 16'd1;
        bb   = (tof(i) == 0 || an) ? {1'b0, bi} : {1'b0, ~bi};
        full = ({1'b0, ai} & m) + (bb & m) + {15'd0, ci};
        e.s   = full[14:0] & m[14:0];
        e.c   = full[wof(i)];
        e.acc = 0;
        return e;
    endfunction

    exp_t        sb [ND][$];
    int          n_chk = 0, n_fail = 0, cyc = 0;
    int          last_stall [ND] = '{default: -1};
    logic [ND-1:0] hold = '0, hold_c = '0;
    logic [14:0] hold_s [ND];

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            for (int i = 0; i < ND; i++) begin
                sb[i].delete();
                hold[i] = 1'b0;
                n_chk++;
                if (v_out_valid[i] !== 1'b0 || v_sum[i] !== 15'd0 || v_cout[i] !== 1'b0 ||
                    v_in_ready[i] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL reset_state dut%0d: out_valid=%b sum=%h cout=%b in_ready=%b, want 0 0000 0 1",
                             i, v_out_valid[i], v_sum[i], v_cout[i], v_in_ready[i]);
                end
            end
        end else if (fin_req) begin
            for (int i = 0; i < ND; i++) begin
                n_chk++;
                if (sb[i].size() != 0) begin
                    n_fail++;
                    $display("FAIL drain dut%0d: %0d results outstanding, want 0", i, sb[i].size());
                end
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end else begin
            for (int i = 0; i < ND; i++) begin
                if (hold[i]) begin
                    n_chk++;
                    if (v_out_valid[i] !== 1'b1 || v_sum[i] !== hold_s[i] || v_cout[i] !== hold_c[i]) begin
                        n_fail++;
                        $display("FAIL stall_hold dut%0d: out_valid=%b sum=%h cout=%b, want 1 %h %b",
                                 i, v_out_valid[i], v_sum[i], v_cout[i], hold_s[i], hold_c[i]);
                    end
                end
                n_chk++;
                if (v_in_ready[i] !== (!v_out_valid[i] || out_ready)) begin
                    n_fail++;
                    $display("FAIL in_ready dut%0d: got %b with out_valid=%b out_ready=%b",
                             i, v_in_ready[i], v_out_valid[i], out_ready);
                end
                if (v_out_valid[i] && !out_ready) begin
                    hold[i]       = 1'b1;
                    hold_s[i]     = v_sum[i];
                    hold_c[i]     = v_cout[i];
                    last_stall[i] = cyc;
                end else begin
                    hold[i] = 1'b0;
                end
                if (v_out_valid[i] && out_ready) begin
                    if (sb[i].size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_out dut%0d: sum=%h cout=%b with nothing outstanding",
                                 i, v_sum[i], v_cout[i]);
                    end else begin
                        e = sb[i].pop_front();
                        n_chk++;
                        if (v_sum[i] !== e.s || v_cout[i] !== e.c) begin
                            n_fail++;
                            $display("FAIL result dut%0d: sum=%h cout=%b, want sum=%h cout=%b",
                                     i, v_sum[i], v_cout[i], e.s, e.c);
                        end
                        if (e.acc > last_stall[i]) begin
                            n_chk++;
                            if (cyc - e.acc != cof(i)) begin
                                n_fail++;
                                $display("FAIL latency dut%0d: %0d cycles, want %0d",
                                         i, cyc - e.acc, cof(i));
                            end
                        end
                    end
                end
                if (in_valid && v_in_ready[i]) begin
                    if (hv && i < 2) begin
                        e.s = (i == 0) ? hs0 : hs1;
                        e.c = (i == 0) ? hc0 : hc1;
                    end else begin
                        e = model(i, a, b, cin, add_nsub);
                    end
                    e.acc = cyc;
                    sb[i].push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    // Directed vector with hand-computed results for the 15-bit ADD (s0/c0) and ADDSUB (s1/c1) units.
    task automatic hand(input logic [14:0] ai, input logic [14:0] bi, input logic ci, input logic an,
                        input logic [14:0] s0, input logic c0, input logic [14:0] s1, input logic c1);
        a = ai; b = bi; cin = ci; add_nsub = an; in_valid = 1'b1;
        hv = 1'b1; hs0 = s0; hc0 = c0; hs1 = s1; hc1 = c1;
        step();
        hv = 1'b0;
    endtask

    task automatic rnd();
        a = 15'($urandom); b = 15'($urandom);
        cin = 1'($urandom); add_nsub = 1'($urandom);
        in_valid = 1'b1;
        step();
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        idle(2);

        hand(15'h7FFF, 15'h0001, 1'b0, 1'b1, 15'h0000, 1'b1, 15'h0000, 1'b1);
        idle(6);

        hand(15'd5, 15'd7, 1'b1, 1'b0, 15'd13, 1'b0, 15'h7FFE, 1'b0);
        hand(15'd7, 15'd5, 1'b1, 1'b0, 15'd13, 1'b0, 15'h0002, 1'b1);
        hand(15'd3, 15'd4, 1'b0, 1'b1, 15'd7,  1'b0, 15'd7,    1'b0);
        idle(6);

        repeat (16) rnd();
        out_ready = 1'b0;
        repeat (3) rnd();
        out_ready = 1'b1;
        repeat (4) rnd();
        idle(6);

        rnd();
        rnd();
        idle(1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(6);

        repeat (16) rnd();
        idle(8);
        fin_req = 1'b1;
    end
endmodule
